// File: rtl/pwm_capture16_if.sv
// pwm_capture16_if: PWM pin in, measured duty/high/period plus valid and stuck status out.
interface pwm_capture16_if;
  logic        pwm_in;
  logic [15:0] duty_cycle;
  logic [16:0] high_cycles;
  logic [16:0] period;
  logic        valid;
  logic        stuck;
  logic        stuck_level;
  modport master (output pwm_in, input duty_cycle, high_cycles, period, valid, stuck, stuck_level);
  modport slave (input pwm_in, output duty_cycle, high_cycles, period, valid, stuck, stuck_level);
endinterface

// File: rtl/pwm_capture16.sv
// pwm_capture16: recovers duty/high/period of an async PWM input, flags edge-free input (PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample filter).
module pwm_capture16 #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [16:0] TIMEOUT     = 17'h1FFFF
) (
  input logic            clk,
  input logic            reset_n,
  pwm_capture16_if.slave bus
);
  typedef enum logic [1:0] {NO_EDGE, ARMED, STUCK} state_t;
  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d, w_s, w_rise, w_capture, w_enter, w_stuck;
  logic [16:0]            r_per, r_hi, w_hm1, r_high, r_period;
  logic [15:0]            r_duty;
  logic                   r_valid;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pwm_in};
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] r_flt;
  logic       r_hold;
  logic [2:0] w_win;
  assign w_win = {r_flt, r_sync[SYNC_STAGES-1]};
  assign w_s = (&w_win || ~|w_win) ? w_win[0] : r_hold;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_flt  <= '0;
      r_hold <= 1'b0;
    end else begin
      r_flt  <= w_win[1:0];
      r_hold <= w_s;
    end
`else
  assign w_s = r_sync[SYNC_STAGES-1];
`endif
  assign w_rise    = w_s & ~r_s_d;
  assign w_enter   = (r_per >= TIMEOUT) && !w_rise && r_state != STUCK;
  assign w_capture = w_rise && r_state == ARMED;
  assign w_hm1     = r_hi - 17'd1;
  assign w_stuck   = r_state == STUCK && !w_rise;
  always_comb begin
    w_next = r_state;
    w_next = w_rise ? ARMED : (w_enter ? STUCK : r_state);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= NO_EDGE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_s_d    <= 1'b0;
      r_per    <= '0;
      r_hi     <= '0;
      r_duty   <= '0;
      r_high   <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_s_d   <= w_s;
      r_per   <= w_rise ? 17'd1 : r_per + {16'd0, ~&r_per};
      r_hi    <= w_rise ? 17'd1 : r_hi + {16'd0, w_s & ~&r_hi};
      r_valid <= w_capture | w_enter;
      if (w_capture) begin
        r_period <= r_per;
        r_high   <= r_hi;
        r_duty   <= w_hm1[16] ? 16'hFFFF : w_hm1[15:0];
      end else if (w_enter) begin
        r_period <= TIMEOUT;
        r_high   <= w_s ? TIMEOUT : 17'd0;
        r_duty   <= w_s ? 16'hFFFF : 16'd0;
      end
    end
  assign bus.duty_cycle  = r_duty;
  assign bus.high_cycles = r_high;
  assign bus.period      = r_period;
  assign bus.valid       = r_valid;
  assign bus.stuck       = w_stuck;
  assign bus.stuck_level = w_stuck & w_s;
endmodule
